shop_cmd_decoder: RTL and testbench

Responder-side front end for the shop command interface. It accepts i_rdy-strobed 24-bit ASCII words with a user ID, and assembles each 4-word frame (3 key words plus 1 argument word). It decodes the command key to an opcode, enforces session and permission rules, and issues a one-cycle decoded-command strobe to the shop datapath. A 3-char ASCII status word goes back on o_a.

---
 rtl/shop_cmd_decoder.sv | 211 +++++++++++++++++++++
 tb/tb_shop_cmd_decoder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shop_cmd_decoder.sv
// Shop command front end: assembles 4-word ASCII frames (3 key words + 1 argument word),
// decodes the key, enforces session/permission rules and issues a one-cycle command strobe.
module shop_cmd_decoder #(
  parameter int unsigned I_A_NUM_BITS = 24,
  parameter int unsigned I_U_NUM_BITS = 4,
  parameter int unsigned O_A_NUM_BITS = 24,
  parameter int unsigned MAX_USERS    = 5,
  parameter logic [I_A_NUM_BITS-1:0] ADMIN_USERNAME = I_A_NUM_BITS'("Adm")
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_rdy,
  input  logic [I_U_NUM_BITS-1:0] i_u,
  input  logic [I_A_NUM_BITS-1:0] i_a,
  output logic [O_A_NUM_BITS-1:0] o_a,
  output logic                    o_cmd_vld,
  output logic [2:0]              o_cmd,
  output logic [I_U_NUM_BITS-1:0] o_cmd_u,
  output logic [I_A_NUM_BITS-1:0] o_cmd_arg,
  output logic                    o_sess_vld,
  output logic [I_U_NUM_BITS-1:0] o_sess_u,
  output logic                    o_sess_adm
);

  localparam int unsigned KeyW = 3 * I_A_NUM_BITS;

  localparam logic [KeyW-1:0] KeyLogout  = KeyW'("Logout");
  localparam logic [KeyW-1:0] KeyLogin   = KeyW'("Login");
  localparam logic [KeyW-1:0] KeyAddUser = KeyW'("AddUsr");
  localparam logic [KeyW-1:0] KeyDelUser = KeyW'("DelUsr");
  localparam logic [KeyW-1:0] KeyAddItem = KeyW'("AddItem");
  localparam logic [KeyW-1:0] KeyDelItem = KeyW'("DelItem");
  localparam logic [KeyW-1:0] KeyBuy     = KeyW'("Buy");
  localparam logic [KeyW-1:0] KeyNone    = KeyW'("NONE");

  localparam logic [O_A_NUM_BITS-1:0] RspOk  = O_A_NUM_BITS'("Ok");
  localparam logic [O_A_NUM_BITS-1:0] RspDen = O_A_NUM_BITS'("Den");
  localparam logic [O_A_NUM_BITS-1:0] RspBad = O_A_NUM_BITS'("Bad");
  localparam logic [O_A_NUM_BITS-1:0] RspNop = O_A_NUM_BITS'("Nop");
  localparam logic [O_A_NUM_BITS-1:0] RspFrm = O_A_NUM_BITS'("Frm");

  localparam logic [I_U_NUM_BITS-1:0] MaxUserId = I_U_NUM_BITS'(MAX_USERS);

  typedef enum logic [2:0] {StIdle, StKey1, StKey2, StArg, StDecode} state_e;
  typedef enum logic [2:0] {
    OpNone, OpLogout, OpLogin, OpAddUser, OpDelUser, OpAddItem, OpDelItem, OpBuy
  } op_e;

  state_e                  state_q, state_d;
  logic                    rdy_q;
  logic [KeyW-1:0]         key_q, key_d;
  logic [I_U_NUM_BITS-1:0] u_q, u_d;
  logic [I_A_NUM_BITS-1:0] arg_q, arg_d;
  logic [O_A_NUM_BITS-1:0] a_q, a_d;
  logic                    cmd_vld_q, cmd_vld_d;
  op_e                     cmd_q, cmd_d;
  logic [I_U_NUM_BITS-1:0] cmd_u_q, cmd_u_d;
  logic [I_A_NUM_BITS-1:0] cmd_arg_q, cmd_arg_d;
  logic                    sess_vld_q, sess_vld_d;
  logic [I_U_NUM_BITS-1:0] sess_u_q, sess_u_d;
  logic                    sess_adm_q, sess_adm_d;

  logic accept;
  logic key_known;
  op_e  key_op;
  logic adm_only;

  assign accept = i_rdy & ~rdy_q;

  always_comb begin
    key_known = 1'b1;
    key_op    = OpNone;
    case (key_q)
      KeyLogout:  key_op = OpLogout;
      KeyLogin:   key_op = OpLogin;
      KeyAddUser: key_op = OpAddUser;
      KeyDelUser: key_op = OpDelUser;
      KeyAddItem: key_op = OpAddItem;
      KeyDelItem: key_op = OpDelItem;
      KeyBuy:     key_op = OpBuy;
      KeyNone:    key_op = OpNone;
      default:    key_known = 1'b0;
    endcase
  end

  assign adm_only = (key_op == OpAddUser) || (key_op == OpDelUser) ||
                    (key_op == OpAddItem) || (key_op == OpDelItem);

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    u_d        = u_q;
    arg_d      = arg_q;
    a_d        = a_q;
    cmd_vld_d  = 1'b0;
    cmd_d      = cmd_q;
    cmd_u_d    = cmd_u_q;
    cmd_arg_d  = cmd_arg_q;
    sess_vld_d = sess_vld_q;
    sess_u_d   = sess_u_q;
    sess_adm_d = sess_adm_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          key_d[KeyW-1 -: I_A_NUM_BITS] = i_a;
          u_d     = i_u;
          state_d = StKey1;
        end
      end
      StKey1, StKey2, StArg: begin
        if (accept) begin
          // A word from a different user aborts the frame and is dropped entirely.
          if (i_u != u_q) begin
            a_d     = RspFrm;
            state_d = StIdle;
          end else if (state_q == StKey1) begin
            key_d[2*I_A_NUM_BITS-1 -: I_A_NUM_BITS] = i_a;
            state_d = StKey2;
          end else if (state_q == StKey2) begin
            key_d[I_A_NUM_BITS-1:0] = i_a;
            state_d = StArg;
          end else begin
            arg_d   = i_a;
            state_d = StDecode;
          end
        end
      end
      StDecode: begin
        state_d = StIdle;
        if (!key_known) begin
          a_d = RspBad;
        end else if (key_op == OpNone) begin
          a_d = RspNop;
        end else if (u_q >= MaxUserId) begin
          a_d = RspBad;
        end else if (key_op == OpLogin) begin
          if (!sess_vld_q) begin
            sess_vld_d = 1'b1;
            sess_u_d   = u_q;
            sess_adm_d = (arg_q == ADMIN_USERNAME);
            a_d        = RspOk;
            cmd_vld_d  = 1'b1;
          end else begin
            a_d = RspDen;
          end
        end else if (!sess_vld_q || (u_q != sess_u_q)) begin
          a_d = RspDen;
        end else if (adm_only && !sess_adm_q) begin
          a_d = RspDen;
        end else begin
          if (key_op == OpLogout) begin
            sess_vld_d = 1'b0;
            sess_u_d   = '0;
            sess_adm_d = 1'b0;
          end
          a_d       = RspOk;
          cmd_vld_d = 1'b1;
        end
        if (cmd_vld_d) begin
          cmd_d     = key_op;
          cmd_u_d   = u_q;
          cmd_arg_d = arg_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q    <= StIdle;
      rdy_q      <= 1'b0;
      key_q      <= '0;
      u_q        <= '0;
      arg_q      <= '0;
      a_q        <= '0;
      cmd_vld_q  <= 1'b0;
      cmd_q      <= OpNone;
      cmd_u_q    <= '0;
      cmd_arg_q  <= '0;
      sess_vld_q <= 1'b0;
      sess_u_q   <= '0;
      sess_adm_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= i_rdy;
      key_q      <= key_d;
      u_q        <= u_d;
      arg_q      <= arg_d;
      a_q        <= a_d;
      cmd_vld_q  <= cmd_vld_d;
      cmd_q      <= cmd_d;
      cmd_u_q    <= cmd_u_d;
      cmd_arg_q  <= cmd_arg_d;
      sess_vld_q <= sess_vld_d;
      sess_u_q   <= sess_u_d;
      sess_adm_q <= sess_adm_d;
    end
  end

  assign o_a        = a_q;
  assign o_cmd_vld  = cmd_vld_q;
  assign o_cmd      = cmd_q;
  assign o_cmd_u    = cmd_u_q;
  assign o_cmd_arg  = cmd_arg_q;
  assign o_sess_vld = sess_vld_q;
  assign o_sess_u   = sess_u_q;
  assign o_sess_adm = sess_adm_q;

endmodule

// File: tb/tb_shop_cmd_decoder.sv
// Self-checking bench for shop_cmd_decoder: scenario tasks push expected frame results to a
// scoreboard and compare the full output vector one cycle after the argument word.
module tb_shop_cmd_decoder;

  localparam logic [23:0] ROk  = 24'h004F6B;
  localparam logic [23:0] RDen = 24'h44656E;
  localparam logic [23:0] RBad = 24'h426164;
  localparam logic [23:0] RNop = 24'h4E6F70;
  localparam logic [23:0] RFrm = 24'h46726D;

  localparam logic [71:0] KLogout  = 72'h000000_4C6F67_6F7574;
  localparam logic [71:0] KLogin   = 72'h00000000_4C6F67696E;
  localparam logic [71:0] KAddUsr  = 72'h000000_416464_557372;
  localparam logic [71:0] KDelItem = 72'h0000_44656C4974656D;
  localparam logic [71:0] KBuy     = 72'h000000000000_427579;
  localparam logic [71:0] KNone    = 72'h0000000000_4E4F4E45;
  localparam logic [71:0] KFoo     = 72'h000000000000_466F6F;

  localparam logic [23:0] Adm = 24'h41646D;
  localparam logic [23:0] Bob = 24'h426F62;

  typedef struct packed {
    logic [23:0] a;
    logic        vld;
    logic [2:0]  cmd;
    logic [3:0]  u;
    logic [23:0] arg;
    logic        sv;
    logic [3:0]  su;
    logic        sa;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_rdy = 1'b0;
  logic [3:0]  i_u = '0;
  logic [23:0] i_a = '0;
  logic [23:0] o_a;
  logic        o_cmd_vld;
  logic [2:0]  o_cmd;
  logic [3:0]  o_cmd_u;
  logic [23:0] o_cmd_arg;
  logic        o_sess_vld;
  logic [3:0]  o_sess_u;
  logic        o_sess_adm;

  exp_t obs;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  assign obs = {o_a, o_cmd_vld, o_cmd, o_cmd_u, o_cmd_arg, o_sess_vld, o_sess_u, o_sess_adm};

  shop_cmd_decoder dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_rdy      (i_rdy),
    .i_u        (i_u),
    .i_a        (i_a),
    .o_a        (o_a),
    .o_cmd_vld  (o_cmd_vld),
    .o_cmd      (o_cmd),
    .o_cmd_u    (o_cmd_u),
    .o_cmd_arg  (o_cmd_arg),
    .o_sess_vld (o_sess_vld),
    .o_sess_u   (o_sess_u),
    .o_sess_adm (o_sess_adm)
  );

  always #5 i_clk = ~i_clk;

  function automatic exp_t mk(logic [23:0] a, logic v, logic [2:0] c, logic [3:0] u,
                              logic [23:0] g, logic sv, logic [3:0] su, logic sa);
    return '{a, v, c, u, g, sv, su, sa};
  endfunction

  task automatic send_word(input logic [3:0] u, input logic [23:0] w);
    @(negedge i_clk);
    i_u   = u;
    i_a   = w;
    i_rdy = 1'b1;
    @(negedge i_clk);
    i_rdy = 1'b0;
  endtask

  task automatic frame(input logic [3:0] u, input logic [71:0] key, input logic [23:0] arg,
                       input exp_t e);
    send_word(u, key[71:48]);
    send_word(u, key[47:24]);
    send_word(u, key[23:0]);
    sb.push_back(e);
    send_word(u, arg);
  endtask

  task automatic test_reset();
    exp_t e;
    i_reset = 1'b0;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b1;
    sb.push_back('0);
    @(negedge i_clk);
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_state: got %h exp %h", obs, e);
    end
  endtask

  task automatic test_admin();
    logic [3:0]  us[3];
    logic [71:0] ks[3];
    logic [23:0] as[3];
    exp_t        es[3];
    exp_t        e;
    us = '{4'd0, 4'd0, 4'd0};
    ks = '{KLogin, KAddUsr, KLogout};
    as = '{Adm, Bob, 24'h0};
    es[0] = mk(ROk, 1, 3'd2, 4'd0, Adm, 1, 4'd0, 1);
    es[1] = mk(ROk, 1, 3'd3, 4'd0, Bob, 1, 4'd0, 1);
    es[2] = mk(ROk, 1, 3'd1, 4'd0, 24'h0, 0, 4'd0, 0);
    for (int i = 0; i < 3; i++) begin
      frame(us[i], ks[i], as[i], es[i]);
      @(negedge i_clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL admin row %0d: got %h exp %h", i, obs, e);
      end
      @(negedge i_clk);
      checks++;
      if (o_cmd_vld !== 1'b0) begin
        errors++;
        $display("FAIL admin strobe_width row %0d: got %b exp 0", i, o_cmd_vld);
      end
    end
  endtask

  task automatic test_permission();
    logic [3:0]  us[7];
    logic [71:0] ks[7];
    logic [23:0] as[7];
    exp_t        es[7];
    exp_t        e;
    us = '{4'd2, 4'd2, 4'd3, 4'd2, 4'd7, 4'd2, 4'd2};
    ks = '{KLogin, KDelItem, KBuy, KFoo, KBuy, KNone, KBuy};
    as = '{Bob, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, Bob};
    es[0] = mk(ROk,  1, 3'd2, 4'd2, Bob, 1, 4'd2, 0);
    es[1] = mk(RDen, 0, 3'd2, 4'd2, Bob, 1, 4'd2, 0);
    es[2] = mk(RDen, 0, 3'd2, 4'd2, Bob, 1, 4'd2, 0);
    es[3] = mk(RBad, 0, 3'd2, 4'd2, Bob, 1, 4'd2, 0);
    es[4] = mk(RBad, 0, 3'd2, 4'd2, Bob, 1, 4'd2, 0);
    es[5] = mk(RNop, 0, 3'd2, 4'd2, Bob, 1, 4'd2, 0);
    es[6] = mk(ROk,  1, 3'd7, 4'd2, Bob, 1, 4'd2, 0);
    for (int i = 0; i < 7; i++) begin
      frame(us[i], ks[i], as[i], es[i]);
      @(negedge i_clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL permission row %0d: got %h exp %h", i, obs, e);
      end
      @(negedge i_clk);
      checks++;
      if (o_cmd_vld !== 1'b0) begin
        errors++;
        $display("FAIL permission strobe_width row %0d: got %b exp 0", i, o_cmd_vld);
      end
    end
    // Second login while a session is open is refused.
    frame(4'd2, KLogin, Bob, mk(RDen, 0, 3'd7, 4'd2, Bob, 1, 4'd2, 0));
    @(negedge i_clk);
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL relogin: got %h exp %h", obs, e);
    end
  endtask

  task automatic test_frame_abort();
    exp_t e;
    logic [71:0] k;
    k = KBuy;
    send_word(4'd2, k[71:48]);
    sb.push_back(mk(RFrm, 0, 3'd7, 4'd2, Bob, 1, 4'd2, 0));
    send_word(4'd3, k[47:24]);
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL frame_abort: got %h exp %h", obs, e);
    end
    frame(4'd2, KBuy, 24'h123456, mk(ROk, 1, 3'd7, 4'd2, 24'h123456, 1, 4'd2, 0));
    @(negedge i_clk);
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL after_abort: got %h exp %h", obs, e);
    end
  endtask

  task automatic test_rdy_hold();
    exp_t e;
    logic [71:0] k;
    k = KBuy;
    @(negedge i_clk);
    i_u   = 4'd2;
    i_a   = k[71:48];
    i_rdy = 1'b1;
    repeat (5) @(negedge i_clk);
    i_rdy = 1'b0;
    send_word(4'd2, k[47:24]);
    send_word(4'd2, k[23:0]);
    sb.push_back(mk(ROk, 1, 3'd7, 4'd2, 24'h00ABCD, 1, 4'd2, 0));
    send_word(4'd2, 24'h00ABCD);
    @(negedge i_clk);
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL rdy_hold: got %h exp %h", obs, e);
    end
    @(negedge i_clk);
    checks++;
    if (o_cmd_vld !== 1'b0) begin
      errors++;
      $display("FAIL rdy_hold strobe_width: got %b exp 0", o_cmd_vld);
    end
  endtask

  task automatic test_reset_mid_frame();
    exp_t e;
    logic [71:0] k;
    k = KBuy;
    send_word(4'd2, k[71:48]);
    send_word(4'd2, k[47:24]);
    send_word(4'd2, k[23:0]);
    i_reset = 1'b0;
    sb.push_back('0);
    @(negedge i_clk);
    i_reset = 1'b1;
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_mid_frame: got %h exp %h", obs, e);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      checks++;
      if (o_cmd_vld !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_frame no_strobe cycle %0d: got %b exp 0", i, o_cmd_vld);
      end
    end
    frame(4'd0, KLogin, Adm, mk(ROk, 1, 3'd2, 4'd0, Adm, 1, 4'd0, 1));
    @(negedge i_clk);
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL after_reset_login: got %h exp %h", obs, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_admin();
    test_permission();
    test_frame_abort();
    test_rdy_hold();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
